// File: rtl/rt_tick_chain.sv
// ---------------------------------------------------------------------------
// rt_tick_chain
//
// Realtime tick generator built from a chain of programmable down-counting
// dividers. Stage 0 divides sysclk cycles (gated by enable); every later
// stage divides the pulses of the stage before it. Each stage owns a
// runtime-loadable divisor, a sticky event flag and an overrun bit that are
// reported through a read-to-clear status word.
//
// Ports
//   sysclk       in   1                    system clock
//   sysreset     in   1                    synchronous active-high reset
//   enable       in   1                    global gate; low freezes counting
//   div_in       in   WIDTH                divisor write data
//   div_load     in   NUM_STAGES           one-hot per-stage divisor strobe
//   div_out      out  NUM_STAGES*WIDTH     divisor registers, stage k at
//                                          bits [k*WIDTH +: WIDTH]
//   status_read  in   1                    read strobe, clears flags/overruns
//   status_out   out  WIDTH                [NUM_STAGES-1:0] event flags,
//                                          [2*NUM_STAGES-1:NUM_STAGES] overruns
//   pulse        out  NUM_STAGES           single-cycle tick per stage
//
// Parameters
//   NUM_STAGES   number of stages, 1..8
//   WIDTH        counter / divisor / bus width, 2*NUM_STAGES <= WIDTH
//   DEFAULT_DIVS reset divisors, packed like div_out
// ---------------------------------------------------------------------------
module rt_tick_chain #(
   parameter int                          NUM_STAGES   = 3,
   parameter int                          WIDTH        = 16,
   parameter logic [NUM_STAGES*WIDTH-1:0] DEFAULT_DIVS = {16'd50, 16'd20, 16'd50}
) (
   input  logic                        sysclk,
   input  logic                        sysreset,
   input  logic                        enable,
   input  logic [WIDTH-1:0]            div_in,
   input  logic [NUM_STAGES-1:0]       div_load,
   output logic [NUM_STAGES*WIDTH-1:0] div_out,
   input  logic                        status_read,
   output logic [WIDTH-1:0]            status_out,
   output logic [NUM_STAGES-1:0]       pulse
);

   typedef logic [WIDTH-1:0] word_t;

   word_t                 div_q [NUM_STAGES];
   word_t                 cnt_q [NUM_STAGES];
   logic [NUM_STAGES-1:0] ev;
   logic [NUM_STAGES-1:0] flag_q;
   logic [NUM_STAGES-1:0] ovr_q;

   // Counter start value for a divisor: D-1, or 0 for a disabled stage.
   function automatic word_t start_cnt(input word_t d);
      return (d == '0) ? '0 : d - word_t'(1);
   endfunction

   function automatic word_t reset_div(input int k);
      return DEFAULT_DIVS[k*WIDTH +: WIDTH];
   endfunction

   // -----------------------------------------------------------------------
   // Pulse chain. Every pulse is combinational from registered state, so a
   // carry ripples through all stages in the same cycle; this is what makes
   // pulse[k] coincide with the pulse[k-1] that produced it.
   // A pending divisor write and reset both mask the stage's pulse.
   // -----------------------------------------------------------------------
   always_comb begin : tick_chain
      logic carry;
      carry = enable;
      ev    = '0;
      pulse = '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
         ev[k]    = carry;
         pulse[k] = carry
                  && (cnt_q[k] == '0)
                  && (div_q[k] != '0)
                  && !div_load[k]
                  && !sysreset;
         carry    = pulse[k];
      end
   end

   // -----------------------------------------------------------------------
   // Divisor and counter registers.
   // A write restarts the phase of its stage and wins over a same-cycle
   // event; a zero divisor parks the counter at 0 and starves the stages
   // further down the chain.
   // -----------------------------------------------------------------------
   always_ff @(posedge sysclk) begin
      if (sysreset) begin
         for (int k = 0; k < NUM_STAGES; k++) begin
            div_q[k] <= reset_div(k);
            cnt_q[k] <= start_cnt(reset_div(k));
         end
      end else begin
         for (int k = 0; k < NUM_STAGES; k++) begin
            if (div_load[k]) begin
               div_q[k] <= div_in;
               cnt_q[k] <= start_cnt(div_in);
            end else if (ev[k] && (div_q[k] != '0)) begin
               if (cnt_q[k] == '0) begin
                  cnt_q[k] <= div_q[k] - word_t'(1);
               end else begin
                  cnt_q[k] <= cnt_q[k] - word_t'(1);
               end
            end
         end
      end
   end

   // -----------------------------------------------------------------------
   // Sticky flags and overruns.
   // A read clears everything, but a pulse in the read cycle re-arms its
   // flag so that event is not lost; it cannot be an overrun because the
   // software has just consumed the previous one.
   // -----------------------------------------------------------------------
   always_ff @(posedge sysclk) begin
      if (sysreset) begin
         flag_q <= '0;
         ovr_q  <= '0;
      end else begin
         for (int k = 0; k < NUM_STAGES; k++) begin
            if (status_read) begin
               flag_q[k] <= pulse[k];
               ovr_q[k]  <= 1'b0;
            end else if (pulse[k]) begin
               flag_q[k] <= 1'b1;
               if (flag_q[k]) begin
                  ovr_q[k] <= 1'b1;
               end
            end
         end
      end
   end

   // -----------------------------------------------------------------------
   // Bus-side views.
   // -----------------------------------------------------------------------
   always_comb begin
      div_out = '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
         div_out[k*WIDTH +: WIDTH] = div_q[k];
      end
   end

   always_comb begin
      status_out                                = '0;
      status_out[NUM_STAGES-1:0]                = flag_q;
      status_out[2*NUM_STAGES-1:NUM_STAGES]     = ovr_q;
   end

endmodule

// File: tb/tb_rt_tick_chain.sv
// ---------------------------------------------------------------------------
// tb_rt_tick_chain
//
// Directed bench for rt_tick_chain with the default three-stage
// configuration (50 / 20 / 50). A reference model counts events per stage
// since the last phase restart and pulses counted since the last status
// read; a compare process checks pulse, status_out and div_out against it on
// every negative clock edge. Hand-computed cycle numbers and status words
// pin the model at the interesting points.
//
// Cycle numbering: cycle 1 is the first clock period after sysreset is
// released.
// ---------------------------------------------------------------------------
module tb_rt_tick_chain;

   localparam int NS = 3;
   localparam int W  = 16;
   localparam logic [NS*W-1:0] DEFS = {16'd50, 16'd20, 16'd50};

   logic            sysclk      = 1'b0;
   logic            sysreset    = 1'b1;
   logic            enable      = 1'b0;
   logic [W-1:0]    div_in      = '0;
   logic [NS-1:0]   div_load    = '0;
   logic            status_read = 1'b0;
   logic [NS*W-1:0] div_out;
   logic [W-1:0]    status_out;
   logic [NS-1:0]   pulse;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   bit chk_en   = 1'b0;

   int m_div  [NS];
   int m_seen [NS];
   int m_rd   [NS];

   rt_tick_chain #(
      .NUM_STAGES   (NS),
      .WIDTH        (W),
      .DEFAULT_DIVS (DEFS)
   ) dut (
      .sysclk      (sysclk),
      .sysreset    (sysreset),
      .enable      (enable),
      .div_in      (div_in),
      .div_load    (div_load),
      .div_out     (div_out),
      .status_read (status_read),
      .status_out  (status_out),
      .pulse       (pulse)
   );

   initial forever #5 sysclk = ~sysclk;

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Model: a stage pulses on an event when it has already seen div-1 events
   // (mod div) since its phase last restarted.
   function automatic void model_eval(output logic [NS-1:0] p, output logic [NS-1:0] e);
      logic carry;
      carry = enable;
      for (int k = 0; k < NS; k++) begin
         e[k] = carry;
         if (m_div[k] == 0) p[k] = 1'b0;
         else p[k] = carry && ((m_seen[k] % m_div[k]) == (m_div[k] - 1))
                     && !div_load[k] && !sysreset;
         carry = p[k];
      end
   endfunction

   initial begin
      for (int k = 0; k < NS; k++) begin
         m_div[k]  = int'(DEFS[k*W +: W]);
         m_seen[k] = 0;
         m_rd[k]   = 0;
      end
   end

   always @(posedge sysclk) begin : model
      logic [NS-1:0] p, e;
      model_eval(p, e);
      if (sysreset) begin
         cyc = 1;
         for (int k = 0; k < NS; k++) begin
            m_div[k]  = int'(DEFS[k*W +: W]);
            m_seen[k] = 0;
            m_rd[k]   = 0;
         end
      end else begin
         cyc++;
         for (int k = 0; k < NS; k++) begin
            if (div_load[k]) begin
               m_div[k]  = int'(div_in);
               m_seen[k] = 0;
            end else if (e[k] && m_div[k] != 0) begin
               m_seen[k]++;
            end
            if (status_read) m_rd[k] = p[k] ? 1 : 0;
            else if (p[k] && m_rd[k] < 2) m_rd[k]++;
         end
      end
   end

   always @(negedge sysclk) begin : compare
      logic [NS-1:0]   p, e;
      logic [W-1:0]    st;
      logic [NS*W-1:0] dv;
      if (chk_en) begin
         model_eval(p, e);
         st = '0;
         dv = '0;
         for (int k = 0; k < NS; k++) begin
            st[k]      = (m_rd[k] >= 1);
            st[NS + k] = (m_rd[k] >= 2);
            dv[k*W +: W] = W'(m_div[k]);
         end
         check("pulse", 64'(pulse), 64'(p));
         check("status_out", 64'(status_out), 64'(st));
         check("div_out", 64'(div_out), 64'(dv));
      end
   end

   task automatic step();
      @(posedge sysclk);
      #1;
   endtask

   task automatic sample();
      @(negedge sysclk);
   endtask

   task automatic run_to(input int c);
      while (cyc < c) step();
   endtask

   task automatic reset_dut();
      sysreset    = 1'b1;
      div_load    = '0;
      status_read = 1'b0;
      step();
      step();
      sysreset = 1'b0;
      chk_en   = 1'b1;
   endtask

   task automatic wait_pulse(input int s, input int bound, output int at, output logic [NS-1:0] pv);
      at = -1;
      pv = '0;
      for (int i = 0; i < bound; i++) begin
         sample();
         if (pulse[s] === 1'b1) begin
            at = cyc;
            pv = pulse;
            step();
            return;
         end
         step();
      end
   endtask

   initial begin : stim
      int            at;
      int            n0, n12;
      logic [NS-1:0] pv;

      // Defaults, flags without reads, full chain to stage 2
      enable = 1'b1;
      reset_dut();
      sample();
      check("reset_div_out", 64'(div_out), 64'(DEFS));
      check("reset_status", 64'(status_out), 64'h0);
      check("reset_pulse", 64'(pulse), 64'h0);
      step();
      wait_pulse(0, 200, at, pv);
      check("p0_first", 64'(at), 64'd50);
      sample();
      check("st_one_pulse", 64'(status_out), 64'h0001);
      step();
      wait_pulse(0, 200, at, pv);
      check("p0_second", 64'(at), 64'd100);
      sample();
      check("st_two_pulses", 64'(status_out), 64'h0009);
      step();
      wait_pulse(0, 200, at, pv);
      check("p0_third", 64'(at), 64'd150);
      run_to(160);
      status_read = 1'b1;
      step();
      status_read = 1'b0;
      sample();
      check("st_read_clear", 64'(status_out), 64'h0);
      step();
      wait_pulse(1, 2000, at, pv);
      check("p1_first", 64'(at), 64'd1000);
      check("p1_first_vec", 64'(pv), 64'b011);
      wait_pulse(2, 60000, at, pv);
      check("p2_first", 64'(at), 64'd50000);
      check("p2_first_vec", 64'(pv), 64'b111);

      // enable low for 7 cycles from cycle 20
      reset_dut();
      run_to(20);
      enable = 1'b0;
      for (int i = 0; i < 7; i++) begin
         sample();
         check("gated_no_pulse", 64'(pulse[0]), 64'd0);
         step();
      end
      enable = 1'b1;
      wait_pulse(0, 200, at, pv);
      check("p0_after_gate", 64'(at), 64'd57);

      // divisor write 3 at cycle 10, then again on a terminal-count cycle
      reset_dut();
      run_to(10);
      div_in   = 16'd3;
      div_load = 3'b001;
      sample();
      check("load_no_pulse", 64'(pulse[0]), 64'd0);
      step();
      div_load = '0;
      for (int c = 11; c <= 19; c++) begin
         logic exp_p;
         exp_p = (c == 13) || (c == 16) || (c == 19);
         sample();
         if (c == 11) check("div_out_after_load", 64'(div_out[15:0]), 64'd3);
         check("div3_pulse", 64'(pulse[0]), 64'(exp_p));
         step();
      end
      run_to(25);
      div_in   = 16'd3;
      div_load = 3'b001;
      sample();
      check("load_at_tc_no_pulse", 64'(pulse[0]), 64'd0);
      step();
      div_load = '0;
      wait_pulse(0, 50, at, pv);
      check("p0_after_reload", 64'(at), 64'd28);

      // stage 1 disabled for 5000 cycles, then re-enabled with 20
      reset_dut();
      run_to(5);
      div_in   = 16'd0;
      div_load = 3'b010;
      step();
      div_load = '0;
      n0  = 0;
      n12 = 0;
      for (int i = 0; i < 5000; i++) begin
         sample();
         if (pulse[0]) n0++;
         if (pulse[1] || pulse[2]) n12++;
         step();
      end
      check("starved_p12_count", 64'(n12), 64'd0);
      check("starved_p0_count", 64'(n0), 64'd100);
      div_in   = 16'd20;
      div_load = 3'b010;
      step();
      div_load = '0;
      wait_pulse(1, 2000, at, pv);
      check("p1_resume", 64'(at), 64'd6000);

      // read coincident with a pulse, then overrun, then plain read
      reset_dut();
      run_to(100);
      status_read = 1'b1;
      sample();
      check("read_coincides_pulse", 64'(pulse[0]), 64'd1);
      step();
      status_read = 1'b0;
      sample();
      check("st_read_with_pulse", 64'(status_out), 64'h0001);
      step();
      run_to(150);
      step();
      sample();
      check("st_overrun", 64'(status_out), 64'h0009);
      step();
      status_read = 1'b1;
      step();
      status_read = 1'b0;
      sample();
      check("st_read_only", 64'(status_out), 64'h0);
      step();

      // reset mid-count after non-default divisors
      reset_dut();
      div_in   = 16'd7;
      div_load = 3'b001;
      step();
      div_in   = 16'd5;
      div_load = 3'b100;
      step();
      div_load = '0;
      run_to(730);
      sysreset = 1'b1;
      step();
      sysreset = 1'b0;
      sample();
      check("midreset_div_out", 64'(div_out), 64'(DEFS));
      check("midreset_status", 64'(status_out), 64'h0);
      step();
      wait_pulse(0, 200, at, pv);
      check("p0_after_midreset", 64'(at), 64'd50);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
